// File: rtl/pipeline_pkg.sv
// Shared pipeline types: XLEN, the IF/ID bundle, fetch FSM states.
// Imported by every fetch-side module.
package pipeline_pkg;

  localparam int XLEN = 64;

  localparam logic [XLEN-1:0] RESET_PC_DEF =
    64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] PCPlus4;
  } ifid_t;

  function automatic logic [XLEN-1:0] pc_inc(
    input logic [XLEN-1:0] pc
  );
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of IF/ID bundles between fetch and decode.
// Flush wins over push and pop; the head reads as zero when empty.
module fetch_queue
  import pipeline_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  ifid_t      pdata_i,
  input  logic       pop_i,
  input  logic       flush_i,
  output ifid_t      head_o,
  output logic       valid_o,
  output logic [1:0] count_o
);

  ifid_t      mem_q [2];
  logic       head_q, head_d;
  logic [1:0] cnt_q, cnt_d;
  logic       tail;
  logic       do_push, do_pop;

  assign tail    = head_q ^ cnt_q[0];
  assign do_push = push_i && (cnt_q != 2'd2);
  assign do_pop  = pop_i && (cnt_q != 2'd0);

  always_comb begin
    head_d = head_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      head_d = 1'b0;
      cnt_d  = 2'd0;
    end else begin
      if (do_pop) head_d = ~head_q;
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 2'd1;
        2'b01:   cnt_d = cnt_q - 2'd1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q   <= 1'b0;
      cnt_q    <= 2'd0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      head_q <= head_d;
      cnt_q  <= cnt_d;
      if (do_push && !flush_i) mem_q[tail] <= pdata_i;
    end
  end

  assign valid_o = (cnt_q != 2'd0);
  assign head_o  = valid_o ? mem_q[head_q] : '0;
  assign count_o = cnt_q;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: one outstanding memory request at a time,
// responses queued for decode, execute redirects flush the queue.
module ifetch_unit
  import pipeline_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter int              QDEPTH   = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            StallD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output ifid_t           ifid,
  output logic            ifid_valid
);

  localparam logic [1:0] QD = 2'(QDEPTH);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fpc_q, fpc_d;
  logic [XLEN-1:0] ppc_q, ppc_d;
  logic [1:0]      count;
  logic            accept, push, pop;
  ifid_t           pdata;

  assign imem_req = (state_q == IDLE) && (count < QD)
                 && !PCSrcE && !reset;
  assign accept   = imem_req && imem_ready;
  assign push     = (state_q == WAIT) && imem_rvalid && !PCSrcE;
  assign pop      = ifid_valid && !StallD;

  assign pdata.instr   = imem_rdata;
  assign pdata.PC      = ppc_q;
  assign pdata.PCPlus4 = pc_inc(ppc_q);

  // A response that lands with a redirect is consumed, so WAIT
  // only drains when the stale response is still in flight.
  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    ppc_d   = ppc_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = WAIT;
      WAIT: begin
        if (imem_rvalid)  state_d = IDLE;
        else if (PCSrcE)  state_d = DRAIN;
      end
      DRAIN:   if (imem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    unique case (1'b1)
      PCSrcE: fpc_d = PCTargetE;
      accept: fpc_d = pc_inc(fpc_q);
      default: fpc_d = fpc_q;
    endcase
    if (accept) ppc_d = fpc_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      fpc_q   <= RESET_PC;
      ppc_q   <= '0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      ppc_q   <= ppc_d;
    end
  end

  assign imem_addr = fpc_q;

  fetch_queue u_q (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pdata_i (pdata),
    .pop_i   (pop),
    .flush_i (PCSrcE),
    .head_o  (ifid),
    .valid_o (ifid_valid),
    .count_o (count)
  );

endmodule
